registro_desplazante_n: RTL and testbench

REGISTRO_DESPLAZANTE_N -- requirements
Module: registro_desplazante_n

---
 rtl/registro_desplazante_n.sv | 164 ++++++++++++++++
 tb/tb_registro_desplazante_n.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/registro_desplazante_n.sv
// registro_desplazante_n: WIDTH-bit universal shift register.
// It supports serial shift, circular rotate and parallel load in either direction.
// It has a burst engine (IDLE -> SHIFT -> DONE) that runs `cnt` steps with the
// mode and direction frozen at the start of the burst.
// Optional feature: define REGDESP_ARITH_EN to make modo=2'b11 an arithmetic
// shift. Without it, modo=2'b11 is a parallel load.
module registro_desplazante_n #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] q,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_sOut;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_modo;
    logic             r_dir;
    logic [CW-1:0]    r_count;

    logic [1:0]       w_modo;
    logic             w_dir;
    logic [WIDTH-1:0] w_stepQ;
    logic             w_stepSout;

    // A burst uses the mode and direction latched at its start; otherwise use the live inputs
    always_comb begin
        w_modo = modo;
        w_dir  = dir;
        if (r_state == ST_SHIFT) begin
            w_modo = r_modo;
            w_dir  = r_dir;
        end
    end

    // Next register contents and serial-out bit for one step in the selected mode
    always_comb begin
        w_stepQ    = r_q;
        w_stepSout = r_sOut;
        case (w_modo)
            2'b00: begin
                if (w_dir) begin
                    w_stepQ    = {s_in, r_q[WIDTH-1:1]};
                    w_stepSout = r_q[0];
                end else begin
                    w_stepQ    = {r_q[WIDTH-2:0], s_in};
                    w_stepSout = r_q[WIDTH-1];
                end
            end
            2'b01: begin
                if (w_dir) begin
                    w_stepQ    = {r_q[0], r_q[WIDTH-1:1]};
                    w_stepSout = r_q[0];
                end else begin
                    w_stepQ    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_stepSout = r_q[WIDTH-1];
                end
            end
            2'b10: begin
                w_stepQ = d;
            end
            2'b11: begin
`ifdef REGDESP_ARITH_EN
                if (w_dir) begin
                    w_stepQ    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                    w_stepSout = r_q[0];
                end else begin
                    w_stepQ    = {r_q[WIDTH-2:0], 1'b0};
                    w_stepSout = r_q[WIDTH-1];
                end
`else
                w_stepQ = d;
`endif
            end
            default: begin
                w_stepQ    = r_q;
                w_stepSout = r_sOut;
            end
        endcase
    end

    // Burst FSM with registered data path and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_sOut  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_modo  <= 2'b00;
            r_dir   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enb) begin
                        if (start) begin
                            r_modo  <= modo;
                            r_dir   <= dir;
                            r_count <= cnt;
                            if (cnt != '0) begin
                                r_state <= ST_SHIFT;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_q    <= w_stepQ;
                            r_sOut <= w_stepSout;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (enb) begin
                        r_q     <= w_stepQ;
                        r_sOut  <= w_stepSout;
                        r_count <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign q     = r_q;
    assign s_out = r_sOut;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_registro_desplazante_n.sv
// Testbench for registro_desplazante_n (WIDTH=8).
// The driver pushes the expected post-edge outputs into a queue.
// A negedge monitor pops the queue and compares it against the DUT.
module tb_registro_desplazante_n;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);
`ifdef REGDESP_ARITH_EN
   localparam bit ARITH = 1'b1;
`else
   localparam bit ARITH = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          enb;
   logic          dir;
   logic          s_in;
   logic [1:0]    modo;
   logic [W-1:0]  d;
   logic          start;
   logic [CW-1:0] cnt;
   logic [W-1:0]  q;
   logic          s_out;
   logic          busy;
   logic          done;

   registro_desplazante_n #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .enb(enb), .dir(dir), .s_in(s_in), .modo(modo),
      .d(d), .start(start), .cnt(cnt), .q(q), .s_out(s_out), .busy(busy), .done(done)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] q;
      logic         sOut;
      logic         busy;
      logic         done;
   } expect_t;

   expect_t expQ[$];
   int checksDone   = 0;
   int checksPassed = 0;

   // Reference model: an integer register value plus burst bookkeeping
   int mQ;
   bit mSout;
   bit mBusy;
   bit mDone;
   int mRemain;
   int mLatMode;
   bit mLatDir;

   function automatic void modelReset();
      mQ = 0; mSout = 0; mBusy = 0; mDone = 0; mRemain = 0; mLatMode = 0; mLatDir = 0;
   endfunction

   // One step computed with arithmetic: left = 2q + fill, right = q/2 + fill*2^(W-1)
   function automatic void modelStep(int mode, bit dr, bit sin, int dv);
      bit lsb;
      bit msb;
      bit outBit;
      bit fill;
      lsb = bit'(mQ % 2);
      msb = bit'(mQ / (2 ** (W - 1)));
      if (mode == 2 || (mode == 3 && !ARITH)) begin
         mQ = dv;
         return;
      end
      outBit = dr ? lsb : msb;
      case (mode)
         0: fill = sin;
         1: fill = outBit;
         default: fill = dr ? msb : 1'b0;
      endcase
      if (!dr) mQ = (mQ * 2 + int'(fill)) % (2 ** W);
      else     mQ = mQ / 2 + int'(fill) * (2 ** (W - 1));
      mSout = outBit;
   endfunction

   function automatic void modelEdge(bit en, int md, bit dr, bit sin, int dv, bit st, int cv);
      if (mDone) begin
         mDone = 0;
      end else if (mBusy) begin
         if (en) begin
            modelStep(mLatMode, mLatDir, sin, dv);
            mRemain--;
            if (mRemain == 0) begin
               mBusy = 0;
               mDone = 1;
            end
         end
      end else if (en) begin
         if (st) begin
            mLatMode = md;
            mLatDir  = dr;
            if (cv == 0) mDone = 1;
            else begin
               mBusy   = 1;
               mRemain = cv;
            end
         end else begin
            modelStep(md, dr, sin, dv);
         end
      end
   endfunction

   // Compare one observed value against its expectation and update the counters
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checksDone++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
      else
         checksPassed++;
   endtask

   // Drive one cycle of inputs, step the model, queue the expected post-edge outputs
   task automatic applyStimulus(input bit en, input int md, input bit dr, input bit sin,
                                input int dv, input bit st, input int cv);
      expect_t e;
      enb   = en;
      modo  = 2'(md);
      dir   = dr;
      s_in  = sin;
      d     = W'(dv);
      start = st;
      cnt   = CW'(cv);
      modelEdge(en, md, dr, sin, dv, st, cv);
      @(posedge clk);
      e.q    = W'(mQ);
      e.sOut = mSout;
      e.busy = mBusy;
      e.done = mDone;
      expQ.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: every falling edge, compare the DUT against the oldest expectation
   initial begin
      expect_t mExp;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            mExp = expQ.pop_front();
            checkOutput("sb_q",     32'(q),     32'(mExp.q));
            checkOutput("sb_s_out", 32'(s_out), 32'(mExp.sOut));
            checkOutput("sb_busy",  32'(busy),  32'(mExp.busy));
            checkOutput("sb_done",  32'(done),  32'(mExp.done));
         end
      end
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      int guard;
      rst = 1'b1; enb = 0; dir = 0; s_in = 0; modo = 0; d = 0; start = 0; cnt = 0;
      modelReset();
      @(negedge clk);
      checkOutput("rst_q", 32'(q), 32'h00);
      checkOutput("rst_s_out", 32'(s_out), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_done", 32'(done), 32'h0);
      rst = 1'b0;

      applyStimulus(1, 2, 0, 0, 8'hA5, 0, 0);
      checkOutput("load_q", 32'(q), 32'hA5);
      checkOutput("load_s_out", 32'(s_out), 32'h0);
      applyStimulus(1, 0, 0, 1, 8'h00, 0, 0);
      checkOutput("sl_q", 32'(q), 32'h4B);
      checkOutput("sl_s_out", 32'(s_out), 32'h1);
      applyStimulus(1, 0, 1, 0, 8'h00, 0, 0);
      checkOutput("sr_q", 32'(q), 32'h25);
      checkOutput("sr_s_out", 32'(s_out), 32'h1);

      applyStimulus(1, 2, 0, 0, 8'h81, 0, 0);
      applyStimulus(1, 1, 1, 0, 8'h00, 1, 3);
      checkOutput("rot_start_busy", 32'(busy), 32'h1);
      checkOutput("rot_start_q", 32'(q), 32'h81);
      applyStimulus(1, 0, 0, 1, 8'hFF, 1, 7);
      applyStimulus(1, 0, 0, 1, 8'hFF, 1, 7);
      checkOutput("rot_mid_busy", 32'(busy), 32'h1);
      applyStimulus(1, 0, 0, 1, 8'hFF, 1, 7);
      checkOutput("rot_q", 32'(q), 32'h30);
      checkOutput("rot_s_out", 32'(s_out), 32'h0);
      checkOutput("rot_done", 32'(done), 32'h1);
      checkOutput("rot_busy_end", 32'(busy), 32'h0);
      applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
      checkOutput("rot_done_clear", 32'(done), 32'h0);
      checkOutput("rot_q_hold", 32'(q), 32'h30);

      applyStimulus(1, 2, 0, 0, 8'h3C, 0, 0);
      applyStimulus(1, 0, 0, 0, 8'h00, 1, 4);
      applyStimulus(1, 3, 1, 1, 8'h00, 0, 0);
      applyStimulus(1, 3, 1, 0, 8'h00, 0, 0);
      applyStimulus(0, 2, 1, 1, 8'h00, 1, 1);
      applyStimulus(0, 2, 1, 1, 8'h00, 1, 1);
      checkOutput("pause_busy", 32'(busy), 32'h1);
      checkOutput("pause_q", 32'(q), 32'hF2);
      applyStimulus(1, 3, 1, 1, 8'h00, 0, 0);
      applyStimulus(1, 3, 1, 1, 8'h00, 0, 0);
      checkOutput("pause_final_q", 32'(q), 32'hCB);
      checkOutput("pause_done", 32'(done), 32'h1);
      applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);

      applyStimulus(1, 1, 1, 0, 8'h00, 1, 0);
      checkOutput("cnt0_done", 32'(done), 32'h1);
      checkOutput("cnt0_busy", 32'(busy), 32'h0);
      checkOutput("cnt0_q", 32'(q), 32'hCB);
      applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
      checkOutput("cnt0_done_clear", 32'(done), 32'h0);

      applyStimulus(1, 1, 0, 0, 8'h00, 1, 5);
      applyStimulus(1, 1, 0, 0, 8'h00, 0, 0);
      #2 rst = 1'b1;
      modelReset();
      #1;
      checkOutput("async_rst_q", 32'(q), 32'h00);
      checkOutput("async_rst_busy", 32'(busy), 32'h0);
      checkOutput("async_rst_done", 32'(done), 32'h0);
      checkOutput("async_rst_s_out", 32'(s_out), 32'h0);
      #1 rst = 1'b0;
      @(negedge clk);
      applyStimulus(1, 0, 0, 1, 8'h00, 1, 2);
      applyStimulus(1, 0, 0, 1, 8'h00, 0, 0);
      applyStimulus(1, 0, 0, 1, 8'h00, 0, 0);
      checkOutput("fresh_q", 32'(q), 32'h03);
      checkOutput("fresh_done", 32'(done), 32'h1);
      applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);

      applyStimulus(1, 2, 0, 0, 8'h90, 0, 0);
      applyStimulus(1, 3, 1, 0, 8'h5A, 0, 0);
      checkOutput("mode3_q", 32'(q), ARITH ? 32'hC8 : 32'h5A);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(bit'($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)),
                       bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                       int'($urandom_range(0, 255)), bit'($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 9)));
      end

      @(negedge clk);
      guard = 0;
      while (expQ.size() != 0 && guard < 5) begin
         @(negedge clk);
         guard++;
      end
      if (expQ.size() != 0) begin
         checksDone++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
      end
      $display("%0d/%0d checks passed", checksPassed, checksDone);
      $finish;
   end

endmodule
